glb_iact_buffer: RTL

GLB_IACT_BUFFER -- requirements
Module: glb_iact_buffer

---
 rtl/glb_iact_buffer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/glb_iact_buffer.sv
// Global-buffer slice for input activations: a single fill pass writes FILL_LEN words
// starting at BASE_ADDR, after which the router reads them back with one cycle of latency.
module glb_iact_buffer #(
    parameter int DATA_BITWIDTH     = 16,
    parameter int ADDR_BITWIDTH_GLB = 10,
    parameter int BASE_ADDR         = 100,
    parameter int FILL_LEN          = 25
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         restart,
    input  logic [DATA_BITWIDTH-1:0]     fill_data,
    input  logic                         fill_valid,
    output logic                         fill_ready,
    output logic                         fill_done,
    input  logic                         rd_req,
    input  logic [ADDR_BITWIDTH_GLB-1:0] rd_addr,
    output logic [DATA_BITWIDTH-1:0]     rd_data,
    output logic                         rd_valid,
    output logic                         rd_oob,
    output logic                         rd_err
);

    localparam int CNT_W = $clog2(FILL_LEN + 1);
    localparam int DEPTH = 1 << ADDR_BITWIDTH_GLB;
    localparam logic [ADDR_BITWIDTH_GLB:0] REGION_LO = (ADDR_BITWIDTH_GLB + 1)'(BASE_ADDR);
    localparam logic [ADDR_BITWIDTH_GLB:0] REGION_HI = (ADDR_BITWIDTH_GLB + 1)'(BASE_ADDR + FILL_LEN);
    localparam logic [CNT_W-1:0]           LAST_CNT  = CNT_W'(FILL_LEN - 1);
    localparam logic [ADDR_BITWIDTH_GLB-1:0] BASE    = ADDR_BITWIDTH_GLB'(BASE_ADDR);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        READY
    } state_t;

    state_t                         state;
    logic [CNT_W-1:0]               fill_cnt;
    logic [DATA_BITWIDTH-1:0]       mem [DEPTH];

    logic                           fill_accept;
    logic [ADDR_BITWIDTH_GLB-1:0]   wr_addr;
    logic [ADDR_BITWIDTH_GLB:0]     rd_addr_ext;
    logic                           rd_in_region;

    always_comb begin
        fill_ready   = (state == FILL);
        fill_accept  = fill_ready & fill_valid & ~restart;
        wr_addr      = BASE + ADDR_BITWIDTH_GLB'(fill_cnt);
        // One extra bit so BASE_ADDR+FILL_LEN at the top of the address space still compares correctly
        rd_addr_ext  = {1'b0, rd_addr};
        rd_in_region = (rd_addr_ext >= REGION_LO) && (rd_addr_ext < REGION_HI);
    end

    // Storage has no reset: contents survive reset and restart until the next fill overwrites them
    always_ff @(posedge clk) begin
        if (fill_accept) begin
            mem[wr_addr] <= fill_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            fill_cnt  <= '0;
            fill_done <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_oob    <= 1'b0;
            rd_err    <= 1'b0;
        end else if (restart) begin
            state     <= IDLE;
            fill_cnt  <= '0;
            fill_done <= 1'b0;
            rd_valid  <= 1'b0;
            rd_oob    <= 1'b0;
            rd_err    <= 1'b0;
        end else begin
            fill_done <= 1'b0;
            rd_valid  <= 1'b0;
            rd_oob    <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (fill_valid) begin
                        if (fill_cnt == LAST_CNT) begin
                            fill_cnt  <= '0;
                            fill_done <= 1'b1;
                            state     <= READY;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                end
                READY: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (rd_req) begin
                if (state == READY) begin
                    rd_valid <= 1'b1;
                    if (rd_in_region) begin
                        rd_data <= mem[rd_addr];
                    end else begin
                        rd_data <= '0;
                        rd_oob  <= 1'b1;
                    end
                end else begin
                    rd_err <= 1'b1;
                end
            end
        end
    end

endmodule
